// File: rtl/draw_if.sv
// Object-record input and pixel-output bundle for draw_unit.
// master: record source / pixel sink side; slave: the draw unit itself.
interface draw_if;
    logic [17:0] rec_in;
    logic        draw_go;
    logic        stall;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        done;

    modport master (
        output rec_in, draw_go, stall,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  rec_in, draw_go, stall,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/draw_unit.sv
// Sprite rasteriser: latches an object record and walks a SPRITE_W x SPRITE_H pixel block.
// Optional macro DRAW_CLIP_EN suppresses the strobe for pixels outside the 160x120 screen.
module draw_unit #(
    parameter int SPRITE_W = 4,
    parameter int SPRITE_H = 4
) (
    input logic   clock,
    input logic   reset,
    draw_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    state_t     state, state_nx;
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] base_col;
    logic [2:0] dx, dy;
    logic [7:0] px;
    logic [6:0] py;
    logic       visible;
    logic       last;
    logic       capture, present, advance, finish;

    assign last = (dx == 3'(SPRITE_W - 1)) && (dy == 3'(SPRITE_H - 1));

`ifdef DRAW_CLIP_EN
    logic cx, cy;
    assign {cx, px} = {1'b0, base_x} + {6'b0, dx};
    assign {cy, py} = {1'b0, base_y} + {5'b0, dy};
    assign visible  = !cx && (px < 8'd160) && !cy && (py < 7'd120);
`else
    assign px      = base_x + {5'b0, dx};
    assign py      = base_y + {4'b0, dy};
    assign visible = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        present  = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.draw_go) begin
                    capture  = 1'b1;
                    state_nx = DRAW;
                end
            end
            DRAW: begin
                present = 1'b1;
                if (!bus.stall) begin
                    advance = 1'b1;
                    if (last) state_nx = FINISH;
                end
            end
            FINISH: begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            base_x         <= '0;
            base_y         <= '0;
            base_col       <= '0;
            dx             <= '0;
            dy             <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state        <= state_nx;
            bus.done     <= finish;
            bus.busy     <= capture | present;
            // A stalled cycle still loads the pending pixel, so it is held with the strobe low.
            bus.vga_plot <= advance & visible;
            if (present) begin
                bus.vga_x      <= px;
                bus.vga_y      <= py;
                bus.vga_colour <= base_col;
            end
            if (capture) begin
                base_x   <= bus.rec_in[17:10];
                base_y   <= bus.rec_in[9:3];
                base_col <= bus.rec_in[2:0];
                dx       <= '0;
                dy       <= '0;
            end else if (advance) begin
                if (dx == 3'(SPRITE_W - 1)) begin
                    dx <= '0;
                    dy <= last ? '0 : dy + 3'd1;
                end else begin
                    dx <= dx + 3'd1;
                end
            end
        end
    end
endmodule

// File: doc/draw_unit.md
DRAW_UNIT -- requirements
Module: draw_unit

Interface
REQ-001 SHALL have parameter SPRITE_W, default 4, sprite width in pixels (1..8).
REQ-002 SHALL have parameter SPRITE_H, default 4, sprite height in pixels (1..8).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rec_in  input  18  packed object record: [17:10] x, [9:3] y, [2:0] colour.
REQ-006 SHALL have port draw_go  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port stall  input  1  downstream busy; freezes pixel walk while high.
REQ-008 SHALL have port vga_x  output  8  pixel x coordinate, registered.
REQ-009 SHALL have port vga_y  output  7  pixel y coordinate, registered.
REQ-010 SHALL have port vga_colour  output  3  pixel colour, registered.
REQ-011 SHALL have port vga_plot  output  1  pixel write strobe, registered.
REQ-012 SHALL have port busy  output  1  high from capture until the last pixel is presented.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, DRAW, FINISH.
REQ-015 In IDLE with draw_go=1 at edge N, SHALL latch x, y and colour from rec_in and enter DRAW; rec_in SHALL be ignored after that edge.
REQ-016 In DRAW, SHALL present one pixel per unstalled cycle in raster order: dx 0..SPRITE_W-1 inner, dy 0..SPRITE_H-1 outer.
REQ-017 Pixel (dx,dy) SHALL be output as vga_x = x+dx and vga_y = y+dy, with vga_colour = latched colour; colour 3'b000 (erase) SHALL be drawn like any other colour.
REQ-018 Without stall, pixel k SHALL be valid in cycle N+1+k, and vga_plot SHALL be high for exactly SPRITE_W*SPRITE_H cycles.
REQ-019 While stall=1, SHALL hold vga_x, vga_y and vga_colour, force vga_plot=0, and not advance the counters; the held pixel SHALL be re-presented with vga_plot=1 on the first cycle stall is low.
REQ-020 After the last pixel is presented unstalled, SHALL enter FINISH for one cycle with done=1, busy=0 and vga_plot=0, then return to IDLE.
REQ-021 busy SHALL be 1 in every DRAW cycle, including stalled cycles, and 0 in IDLE and FINISH.
REQ-022 draw_go in DRAW or FINISH SHALL be ignored, neither queued nor restarting; draw_go in IDLE SHALL be accepted on the cycle after FINISH.
REQ-023 Coordinate adders SHALL be 8-bit for x and 7-bit for y; overflow handling SHALL be as set by REQ-027 and REQ-028.
REQ-024 In IDLE, vga_plot and done SHALL be 0, and vga_x, vga_y and vga_colour SHALL hold their last values.

Reset
REQ-025 When reset=1 at an edge, SHALL enter IDLE and clear vga_x, vga_y, vga_colour, vga_plot, busy, done and the dx/dy counters to 0; this SHALL override draw_go and any in-progress draw.
REQ-026 A draw aborted by reset SHALL NOT produce done; the first pixel of the next draw_go SHALL be (x,y) of the new record.

Configuration
REQ-027 With macro DRAW_CLIP_EN defined, pixels with x+dx >= 160, y+dy >= 120 or adder carry-out SHALL be presented with vga_plot=0 but still consume their cycle, so the cycle count is unchanged.
REQ-028 Without DRAW_CLIP_EN, coordinates SHALL wrap modulo 256 (x) and modulo 128 (y), and every pixel SHALL be presented with vga_plot=1.

Verification
REQ-029 rec_in = x=10, y=20, colour=001 with draw_go at cycle 0 -> plots (10,20),(11,20),(12,20),(13,20),(10,21)...(13,23) in cycles 1-16, done=1 in cycle 17.
REQ-030 Same draw with stall=1 during cycles 3-5 -> pixel (12,20) held with vga_plot=0, then plotted in cycle 6; done in cycle 20.
REQ-031 x=158, y=118, DRAW_CLIP_EN -> only x in 158..159 and y in 118..119 plotted, giving 4 strobes; done in cycle 17. Without the macro -> 16 strobes, including x=160 and y=121 plotted.
REQ-032 reset=1 at cycle 8 of a draw -> cycle 9 shows all outputs 0 with no done pulse; a new draw_go at cycle 10 -> first pixel is the new base in cycle 11.
REQ-033 draw_go pulsed at cycles 0, 5 and 17 -> exactly one 16-pixel draw from cycle 0; the cycle-17 request is ignored because the unit is in FINISH; a request at cycle 18 starts a second draw.
REQ-034 colour=000 with SPRITE_W=2, SPRITE_H=3 -> 6 strobes with vga_colour=000, done in cycle 7.
